sync_fifo_prog: RTL and testbench

- Single-clock, parametrised FIFO; the single-domain successor to the team's dual-clock FIFO.
- Adds runtime-programmable almost-full/almost-empty thresholds, an occupancy count, and a selectable read mode (registered or first-word-fall-through).
- Adds read/write pass-through when full, sticky error flags with clear, and synchronous flush.
- Sits between producer/consumer blocks within one clock domain.

---
 rtl/sync_fifo_prog.sv | 118 +++++++++++
 tb/tb_sync_fifo_prog.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, sticky error flags, synchronous flush and selectable read mode.
module sync_fifo_prog #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int SIZE  = $clog2(DEPTH),
  parameter bit FWFT  = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic [SIZE:0]    af_thresh,
  input  logic [SIZE:0]    ae_thresh,
  input  logic             err_clr,
  output logic [SIZE:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [SIZE:0] DEPTH_C = DEPTH[SIZE:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [SIZE:0]    r_wr_ptr, r_rd_ptr, r_count;
  logic             r_ovf, r_udf;
  logic             w_full, w_empty, w_rd_acc, w_wr_acc;

  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  // Flush swallows same-cycle requests, so gate acceptance here once.
  assign w_rd_acc = !flush && rd_en && !w_empty;
  assign w_wr_acc = !flush && wr_en && (!w_full || w_rd_acc);

  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= af_thresh);
  assign almost_empty = (r_count <= ae_thresh);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr[SIZE-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky errors: a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (!flush && wr_en && !w_wr_acc) r_ovf <= 1'b1;
      else if (err_clr)                 r_ovf <= 1'b0;
      if (!flush && rd_en && w_empty)   r_udf <= 1'b1;
      else if (err_clr)                 r_udf <= 1'b0;
    end
  end

  generate
    if (FWFT == 1'b0) begin : g_reg
      logic [WIDTH-1:0] r_rd_data;
      logic             r_rd_valid;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else if (flush) begin
          r_rd_valid <= 1'b0;
        end else if (w_rd_acc) begin
          r_rd_data  <= r_mem[r_rd_ptr[SIZE-1:0]];
          r_rd_valid <= 1'b1;
        end else begin
          r_rd_valid <= 1'b0;
        end
      end
      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
    end else begin : g_fwft
      assign rd_data  = r_mem[r_rd_ptr[SIZE-1:0]];
      assign rd_valid = !w_empty;
    end
  endgenerate

  // Pointer relationship must agree with the occupancy counter.
  a_full_ptr: assert property (@(posedge clk) disable iff (!rstn)
    (((r_wr_ptr[SIZE-1:0] == r_rd_ptr[SIZE-1:0]) && (r_wr_ptr[SIZE] != r_rd_ptr[SIZE])) == w_full));
  a_empty_ptr: assert property (@(posedge clk) disable iff (!rstn)
    ((r_wr_ptr == r_rd_ptr) == w_empty));
  a_count_ptr: assert property (@(posedge clk) disable iff (!rstn)
    ((r_wr_ptr - r_rd_ptr) == r_count));
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: registered-read instance checked through a
// read-data scoreboard, plus a first-word-fall-through instance.
module tb_sync_fifo_prog;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  always #5 clk = ~clk;

  // registered-read instance
  logic       flush, wr_en, rd_en, err_clr;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] af_thresh, ae_thresh, count;

  // first-word-fall-through instance
  logic       flush1, wr_en1, rd_en1, err_clr1;
  logic [7:0] wr_data1, rd_data1;
  logic       rd_valid1, full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0] count1;

  int checks = 0;
  int failures = 0;
  logic [7:0] mdl[$];
  logic [7:0] exp_q[$];

  sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(1'b0)) u_dut (
    .clk(clk), .rstn(rstn), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .err_clr(err_clr), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow),
    .underflow(underflow));

  sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(1'b1)) u_dut_fwft (
    .clk(clk), .rstn(rstn), .flush(flush1), .wr_en(wr_en1), .wr_data(wr_data1),
    .rd_en(rd_en1), .rd_data(rd_data1), .rd_valid(rd_valid1), .af_thresh(5'd14),
    .ae_thresh(5'd2), .err_clr(err_clr1), .count(count1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(udf1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the queue model decides which reads are accepted
  // and pushes the data the DUT must later present.
  task automatic cyc(input bit we, input logic [7:0] wd, input bit re, input bit fl, input bit ec);
    bit ra, wa;
    wr_en = we; wr_data = wd; rd_en = re; flush = fl; err_clr = ec;
    if (fl) mdl.delete();
    else begin
      ra = re && (mdl.size() != 0);
      wa = we && (mdl.size() < 16 || ra);
      if (ra) exp_q.push_back(mdl.pop_front());
      if (wa) mdl.push_back(wd);
    end
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
  endtask

  // Scoreboard monitor: every registered-read valid pops one expected word.
  always @(negedge clk) begin
    if (rstn && rd_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rd_valid", 1, 0);
      else chk("rd_data", rd_data, exp_q.pop_front());
    end
  end

  initial begin
    flush = 0; wr_en = 0; rd_en = 0; err_clr = 0; wr_data = 0;
    af_thresh = 5'd14; ae_thresh = 5'd2;
    flush1 = 0; wr_en1 = 0; rd_en1 = 0; err_clr1 = 0; wr_data1 = 0;
    repeat (3) @(posedge clk); #1;

    // 1: reset state
    chk("rst_empty", empty, 1); chk("rst_ae", almost_empty, 1);
    chk("rst_full", full, 0);   chk("rst_af", almost_full, 0);
    chk("rst_count", count, 0); chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0); chk("rst_ovf", overflow, 0);
    chk("rst_fwft_valid", rd_valid1, 0);
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;
    af_thresh = 5'd0; #1;
    chk("af_thresh0", almost_full, 1);
    af_thresh = 5'd14; #1;

    // 2: fill and overflow
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 8'(i), 0, 0, 0);
      chk("fill_count", count, i);
      chk("fill_ae", almost_empty, (i <= 2) ? 1 : 0);
      chk("fill_af", almost_full, (i >= 14) ? 1 : 0);
      chk("fill_full", full, (i == 16) ? 1 : 0);
    end
    chk("pre_ovf", overflow, 0);
    cyc(1, 8'h11, 0, 0, 0);
    chk("ovf_count", count, 16); chk("ovf_set", overflow, 1);
    cyc(0, 0, 0, 0, 0);
    chk("ovf_sticky", overflow, 1);
    af_thresh = 5'd17; #1;
    chk("af_above_depth", almost_full, 0);
    af_thresh = 5'd14; #1;
    cyc(0, 0, 0, 0, 1);
    chk("ovf_clr", overflow, 0);

    // 3: write+read on full, then drain 0x02..0x10, 0xAA
    cyc(1, 8'hAA, 1, 0, 0);
    chk("pass_count", count, 16); chk("pass_full", full, 1); chk("pass_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0, 0);
      chk("drain_valid", rd_valid, 1);
      chk("drain_data", rd_data, (i < 15) ? i + 2 : 8'hAA);
      chk("drain_count", count, 15 - i);
    end
    cyc(0, 0, 0, 0, 0);
    chk("drain_valid_low", rd_valid, 0); chk("drain_empty", empty, 1);

    // 4: write+read on empty -> read rejected
    cyc(1, 8'h33, 1, 0, 0);
    chk("udf_set", underflow, 1); chk("udf_count", count, 1); chk("udf_no_valid", rd_valid, 0);
    cyc(0, 0, 1, 0, 0);
    chk("udf_next_data", rd_data, 8'h33);
    cyc(0, 0, 0, 0, 1);
    chk("udf_clr", underflow, 0);

    // 5: FWFT instance
    wr_en1 = 1; wr_data1 = 8'h5A;
    @(posedge clk); #1; wr_en1 = 0;
    chk("fwft_valid", rd_valid1, 1); chk("fwft_data", rd_data1, 8'h5A);
    rd_en1 = 1;
    @(posedge clk); #1; rd_en1 = 0;
    chk("fwft_empty", empty1, 1); chk("fwft_valid_low", rd_valid1, 0); chk("fwft_udf", udf1, 0);

    // 6: flush at count 9 with a pending read response, then pointer wrap
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("pre_flush_count", count, 9);
    cyc(1, 8'hEE, 1, 1, 0);
    chk("flush_count", count, 0); chk("flush_empty", empty, 1);
    chk("flush_valid", rd_valid, 0); chk("flush_ovf", overflow, 0); chk("flush_udf", underflow, 0);
    cyc(1, 8'h03, 0, 0, 0);
    for (int i = 1; i < 40; i++) cyc(1, 8'(i * 7 + 3), 1, 0, 0);
    chk("wrap_count", count, 1);
    cyc(0, 0, 1, 0, 0);
    chk("wrap_end_count", count, 0);
    repeat (2) @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
